// File: rtl/fpnew_lane_gather.sv
// fpnew_lane_gather: sequencing engine for a multi-lane FP slice whose lanes
// have independent, variable latency. It takes one operation from upstream,
// dispatches it once to every active lane, holds each lane's result until all
// active lanes are back, then presents one merged result with collapsed status.
//
// Optional build macro: FPNEW_LANE_GATHER_LATCNT_EN adds last_latency_o, which
// holds the accept-to-DONE cycle count of the most recently completed op.
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// on a rising clock edge where valid and ready are both 1. Valid never depends
// on ready. Once raised, a valid stays up until its transfer happens or a
// flush/reset cancels it.
module fpnew_lane_gather #(
    parameter int unsigned Width         = 64,
    parameter int unsigned NumLanes      = 4,
    parameter int unsigned FpWidth       = 16,
    parameter int unsigned TagWidth      = 4,
    parameter bit          EnableVectors = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic                         vectorial_op_i,
    input  logic [NumLanes-1:0]          simd_mask_i,
    input  logic [TagWidth-1:0]          tag_i,
    input  logic                         flush_i,
    output logic [NumLanes-1:0]          lane_in_valid_o,
    input  logic [NumLanes-1:0]          lane_in_ready_i,
    input  logic [NumLanes-1:0]          lane_out_valid_i,
    output logic [NumLanes-1:0]          lane_out_ready_o,
    input  logic [NumLanes*FpWidth-1:0]  lane_result_i,
    input  logic [NumLanes*5-1:0]        lane_status_i,
    input  logic                         lane_ext_bit_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [Width-1:0]             result_o,
    output logic [4:0]                   status_o,
    output logic                         extension_bit_o,
    output logic [TagWidth-1:0]          tag_o,
    output logic                         busy_o
`ifdef FPNEW_LANE_GATHER_LATCNT_EN
    ,
    output logic [15:0]                  last_latency_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Per-operation bookkeeping
    logic [NumLanes-1:0] active_q, mask_q, dispatched_q, collected_q;
    logic [NumLanes-1:0] active_d, dispatch_hs, collect_hs, collected_next;
    logic [TagWidth-1:0] tag_q;
    logic                ext_q;

    // Per-lane holding registers
    logic [NumLanes-1:0][FpWidth-1:0] held_result_q;
    logic [NumLanes-1:0][4:0]         held_status_q;

    logic accept;
    logic busy_live;

    // No accept while reset is held, so every output reads 0 during reset.
    assign in_ready_o = rst_ni & ~flush_i &
                        ((state_q == IDLE) | ((state_q == DONE) & out_ready_i));
    assign accept     = in_valid_i & in_ready_o;

    // Flush kills every lane-side handshake in the cycle it is raised.
    assign busy_live        = (state_q == BUSY) & ~flush_i;
    assign lane_in_valid_o  = {NumLanes{busy_live}} & active_q & ~dispatched_q;
    assign lane_out_ready_o = {NumLanes{busy_live}} & active_q & dispatched_q & ~collected_q;
    assign dispatch_hs      = lane_in_valid_o & lane_in_ready_i;
    assign collect_hs       = lane_out_ready_o & lane_out_valid_i;
    assign collected_next   = collected_q | collect_hs;

    assign out_valid_o     = (state_q == DONE) & ~flush_i;
    assign busy_o          = (state_q != IDLE);
    assign extension_bit_o = ext_q;
    assign tag_o           = tag_q;

    // Lane set for an incoming op: all lanes for vector ops, else lane 0 only.
    always_comb begin
        active_d = '0;
        if (vectorial_op_i && EnableVectors) begin
            active_d = '1;
        end else begin
            active_d[0] = 1'b1;
        end
    end

    // Next-state logic; DONE is entered on the edge where the last active
    // lane is collected, so out_valid_o comes straight from a register.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                if (collected_next == active_q) state_d = DONE;
            end
            DONE: begin
                if (accept) begin
                    state_d = BUSY;
                end else if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operation context and dispatch/collect tracking vectors
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q     <= '0;
            mask_q       <= '0;
            tag_q        <= '0;
            dispatched_q <= '0;
            collected_q  <= '0;
        end else if (flush_i) begin
            dispatched_q <= '0;
            collected_q  <= '0;
        end else if (accept) begin
            active_q     <= active_d;
            mask_q       <= simd_mask_i;
            tag_q        <= tag_i;
            dispatched_q <= '0;
            collected_q  <= '0;
        end else if (state_q == BUSY) begin
            dispatched_q <= dispatched_q | dispatch_hs;
            collected_q  <= collected_next;
        end
    end

    // Capture a lane's result and status on its collection handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            held_result_q <= '0;
            held_status_q <= '0;
            ext_q         <= 1'b0;
        end else begin
            for (int k = 0; k < NumLanes; k++) begin
                if (collect_hs[k]) begin
                    held_result_q[k] <= lane_result_i[k*FpWidth +: FpWidth];
                    held_status_q[k] <= lane_status_i[k*5 +: 5];
                end
            end
            if (collect_hs[0]) ext_q <= lane_ext_bit_i;
        end
    end

    // Merge lane slices with extension fill and OR the enabled lane statuses
    always_comb begin
        result_o = {Width{ext_q}};
        status_o = '0;
        for (int k = 0; k < NumLanes; k++) begin
            if (collected_q[k]) begin
                result_o[k*FpWidth +: FpWidth] = held_result_q[k];
            end
            status_o = status_o | (held_status_q[k] & {5{mask_q[k] & active_q[k]}});
        end
    end

`ifdef FPNEW_LANE_GATHER_LATCNT_EN
    logic [15:0] lat_cnt_q;
    logic [15:0] lat_cnt_inc;

    assign lat_cnt_inc = (lat_cnt_q == 16'hFFFF) ? lat_cnt_q : lat_cnt_q + 16'd1;

    // Saturating accept-to-DONE counter; a flushed op never publishes a value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_cnt_q      <= '0;
            last_latency_o <= '0;
        end else if (flush_i) begin
            lat_cnt_q <= '0;
        end else if (accept) begin
            lat_cnt_q <= 16'd1;
        end else if (state_q == BUSY) begin
            if (state_d == DONE) begin
                last_latency_o <= lat_cnt_inc;
            end else begin
                lat_cnt_q <= lat_cnt_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpnew_lane_gather.sv
// Bench for fpnew_lane_gather: directed table of ops with hand-computed
// expectations, then randomized ops against a lane-level reference model.
module tb_fpnew_lane_gather;

  localparam int W  = 64;
  localparam int NL = 4;
  localparam int FW = 16;
  localparam int TW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              in_valid_i, in_ready_o, vectorial_op_i, flush_i;
  logic [NL-1:0]     simd_mask_i;
  logic [TW-1:0]     tag_i;
  logic [NL-1:0]     lane_in_valid_o, lane_in_ready_i, lane_out_valid_i, lane_out_ready_o;
  logic [NL*FW-1:0]  lane_result_i;
  logic [NL*5-1:0]   lane_status_i;
  logic              lane_ext_bit_i;
  logic              out_valid_o, out_ready_i, extension_bit_o, busy_o;
  logic [W-1:0]      result_o;
  logic [4:0]        status_o;
  logic [TW-1:0]     tag_o;

  fpnew_lane_gather dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .vectorial_op_i(vectorial_op_i), .simd_mask_i(simd_mask_i), .tag_i(tag_i),
    .flush_i(flush_i),
    .lane_in_valid_o(lane_in_valid_o), .lane_in_ready_i(lane_in_ready_i),
    .lane_out_valid_i(lane_out_valid_i), .lane_out_ready_o(lane_out_ready_o),
    .lane_result_i(lane_result_i), .lane_status_i(lane_status_i),
    .lane_ext_bit_i(lane_ext_bit_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .status_o(status_o), .extension_bit_o(extension_bit_o),
    .tag_o(tag_o), .busy_o(busy_o)
  );

  // ---------------- scoreboard state ----------------
  int checks;
  int failures;
  bit in_done;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic             vec;
    logic [3:0]       mask;
    logic [3:0]       tag;
    logic             ext;
    logic [3:0][15:0] vals;
    logic [3:0][4:0]  stats;
    logic [3:0][3:0]  acc;
    logic [3:0][3:0]  lat;
    int               hold;
    bit               retire;
    int               abort_kind;
    int               abort_at;
  } op_t;

  typedef struct {
    op_t        op;
    logic [63:0] exp_res;
    logic [4:0]  exp_stat;
    int          exp_done;
  } vec_t;

  vec_t tab[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] obs();
    return {lane_in_valid_o, lane_out_ready_o, out_valid_o, in_ready_o, busy_o};
  endfunction

  function automatic logic [84:0] outs_all();
    return {in_ready_o, lane_in_valid_o, lane_out_ready_o, out_valid_o, result_o,
            status_o, extension_bit_o, tag_o, busy_o};
  endfunction

  function automatic op_t mk_op(input logic vec, input logic [3:0] mask, input logic [3:0] tag,
                                input logic ext, input logic [63:0] vals, input logic [19:0] stats,
                                input logic [15:0] acc, input logic [15:0] lat, input int hold,
                                input bit retire, input int ak, input int aa);
    op_t o;
    o.vec = vec; o.mask = mask; o.tag = tag; o.ext = ext;
    o.vals = vals; o.stats = stats; o.acc = acc; o.lat = lat;
    o.hold = hold; o.retire = retire; o.abort_kind = ak; o.abort_at = aa;
    return o;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_res(input op_t o);
    logic [63:0] r;
    r = {64{o.ext}};
    for (int k = 0; k < NL; k++)
      if (o.vec || k == 0) r[k*16 +: 16] = o.vals[k];
    return r;
  endfunction

  function automatic logic [4:0] model_stat(input op_t o);
    logic [4:0] s;
    s = '0;
    for (int k = 0; k < NL; k++)
      if ((o.vec || k == 0) && o.mask[k]) s = s | o.stats[k];
    return s;
  endfunction

  // Lane k dispatches no earlier than cycle 1 and returns lat cycles later;
  // out_valid appears the cycle after the last return.
  function automatic int model_done(input op_t o);
    int d, t;
    d = 0;
    for (int k = 0; k < NL; k++) begin
      if (o.vec || k == 0) begin
        t = ((o.acc[k] > 0) ? int'(o.acc[k]) : 1) + int'(o.lat[k]);
        if (t > d) d = t;
      end
    end
    return d + 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic garbage_lanes();
    lane_in_ready_i  = 4'($urandom);
    lane_out_valid_i = 4'($urandom);
    lane_result_i    = {$urandom, $urandom};
    lane_status_i    = 20'($urandom);
    lane_ext_bit_i   = 1'($urandom);
  endtask

  task automatic run_op(input op_t o, input logic [63:0] e_res, input logic [4:0] e_stat,
                        input int e_done);
    logic [3:0] act, disp, coll, liv, lor;
    int dcyc[4];
    int c, first_ov;
    bit done, fin;
    logic [63:0] exp_r;
    act = o.vec ? 4'hF : 4'h1;
    disp = '0;
    coll = '0;
    first_ov = -1;
    for (int k = 0; k < NL; k++) dcyc[k] = 0;
    exp_q.push_back(e_res);

    // accept cycle
    @(negedge clk);
    in_valid_i = 1'b1; vectorial_op_i = o.vec; simd_mask_i = o.mask; tag_i = o.tag;
    out_ready_i = 1'b1;
    garbage_lanes();
    #1 chk("accept", obs(), {4'h0, 4'h0, in_done, 1'b1, in_done});

    c = 1;
    done = 0;
    while (!done && c < 80) begin
      @(negedge clk);
      in_valid_i = 1'b0; out_ready_i = 1'b0;
      vectorial_op_i = 1'($urandom); tag_i = 4'($urandom); simd_mask_i = 4'($urandom);
      if (coll == act) begin
        garbage_lanes();
        #1;
        if (out_valid_o && first_ov < 0) first_ov = c;
        done = 1;
        exp_r = exp_q.pop_front();
        chk("done_cycle", first_ov, e_done);
        chk("done_flags", obs(), {4'h0, 4'h0, 1'b1, 1'b0, 1'b1});
        chk("result", result_o, exp_r);
        chk("status", status_o, e_stat);
        chk("tag_ext", {tag_o, extension_bit_o}, {o.tag, o.ext});
      end else begin
        liv = act & ~disp;
        lor = act & disp & ~coll;
        lane_ext_bit_i = 1'($urandom);
        for (int k = 0; k < NL; k++) begin
          lane_in_ready_i[k] = act[k] ? (!disp[k] && c >= int'(o.acc[k])) : 1'($urandom);
          fin = disp[k] && !coll[k] && (c >= dcyc[k] + int'(o.lat[k]));
          lane_out_valid_i[k] = fin ? 1'b1 : (disp[k] ? 1'b0 : 1'($urandom));
          lane_result_i[k*16 +: 16] = fin ? o.vals[k] : 16'($urandom);
          lane_status_i[k*5 +: 5]   = fin ? o.stats[k] : 5'($urandom);
          if (k == 0 && fin) lane_ext_bit_i = o.ext;
        end
        if (o.abort_kind == 1 && c == o.abort_at) begin
          flush_i = 1'b1;
          #1 chk("flush_same_cycle", obs(), {4'h0, 4'h0, 1'b0, 1'b0, 1'b1});
          @(negedge clk);
          flush_i = 1'b0;
          garbage_lanes();
          #1 chk("flush_next_idle", obs(), {4'h0, 4'h0, 1'b0, 1'b1, 1'b0});
          void'(exp_q.pop_front());
          in_done = 0;
          return;
        end
        if (o.abort_kind == 2 && c == o.abort_at) begin
          #1 rst_n = 1'b0;
          #1 chk("reset_mid_busy", outs_all(), '0);
          @(negedge clk);
          rst_n = 1'b1;
          #1 chk("reset_mid_release", obs(), {4'h0, 4'h0, 1'b0, 1'b1, 1'b0});
          void'(exp_q.pop_front());
          in_done = 0;
          return;
        end
        #1;
        if (out_valid_o && first_ov < 0) first_ov = c;
        chk("busy_cycle", obs(), {liv, lor, 1'b0, 1'b0, 1'b1});
        for (int k = 0; k < NL; k++) begin
          if (liv[k] && lane_in_ready_i[k]) begin
            disp[k] = 1'b1;
            dcyc[k] = c;
          end
        end
        coll = coll | (lor & lane_out_valid_i);
      end
      c++;
    end
    if (!done) chk("model_timeout", 1, 0);

    // backpressure: result held while downstream stalls
    for (int h = 0; h < o.hold; h++) begin
      @(negedge clk);
      in_valid_i = 1'b1; out_ready_i = 1'b0;
      garbage_lanes();
      #1 chk("hold_flags", obs(), {4'h0, 4'h0, 1'b1, 1'b0, 1'b1});
      chk("hold_stable", {result_o, status_o, tag_o, extension_bit_o},
          {e_res, e_stat, o.tag, o.ext});
    end

    if (o.retire) begin
      @(negedge clk);
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      garbage_lanes();
      #1 chk("retire", obs(), {4'h0, 4'h0, 1'b1, 1'b1, 1'b1});
      in_done = 0;
    end else begin
      in_done = 1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    op_t ro;
    checks = 0; failures = 0; in_done = 0;
    rst_n = 1'b0;
    in_valid_i = 0; vectorial_op_i = 0; simd_mask_i = 0; tag_i = 0; flush_i = 0;
    lane_in_ready_i = 0; lane_out_valid_i = 0; lane_result_i = 0; lane_status_i = 0;
    lane_ext_bit_i = 0; out_ready_i = 0;
    #1 chk("reset_outputs", outs_all(), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("reset_release", obs(), {4'h0, 4'h0, 1'b0, 1'b1, 1'b0});

    // scalar op: lane 0 only, ext fill above it
    tab[0] = '{mk_op(1'b0, 4'hF, 4'h3, 1'b1, 64'h1111_2222_3333_3C00,
                     {5'b11111, 5'b11111, 5'b11111, 5'b00001},
                     {4'd0, 4'd0, 4'd0, 4'd0}, {4'd1, 4'd1, 4'd1, 4'd1}, 0, 1'b1, 0, 0),
               64'hFFFF_FFFF_FFFF_3C00, 5'b00001, 3};
    // staggered lanes: accept 1,2,2,5 complete 4,9,3,6; left in DONE
    tab[1] = '{mk_op(1'b1, 4'hF, 4'h5, 1'b0, 64'h4444_3333_2222_1111,
                     {5'b00001, 5'b00010, 5'b00100, 5'b01000},
                     {4'd5, 4'd2, 4'd2, 4'd1}, {4'd1, 4'd1, 4'd7, 4'd3}, 0, 1'b0, 0, 0),
               64'h4444_3333_2222_1111, 5'b01111, 10};
    // back-to-back accept, status collapse under mask 0101, 10-cycle stall
    tab[2] = '{mk_op(1'b1, 4'b0101, 4'h9, 1'b1, 64'hABCD_8765_4321_0FED,
                     {5'b01000, 5'b00100, 5'b00001, 5'b10000},
                     {4'd0, 4'd0, 4'd0, 4'd0}, {4'd1, 4'd1, 4'd1, 4'd1}, 10, 1'b1, 0, 0),
               64'hABCD_8765_4321_0FED, 5'b10100, 3};
    // flush with lanes 0,1 collected and 2,3 outstanding
    tab[3] = '{mk_op(1'b1, 4'hF, 4'h2, 1'b0, 64'h9999_8888_7777_6666,
                     {5'b11111, 5'b11111, 5'b11111, 5'b11111},
                     {4'd0, 4'd0, 4'd0, 4'd0}, {4'd9, 4'd9, 4'd1, 4'd1}, 0, 1'b1, 1, 4),
               64'h0, 5'b0, 0};
    // fresh op after flush: lanes 0,1 now the slow ones
    tab[4] = '{mk_op(1'b1, 4'hF, 4'h7, 1'b1, 64'h1234_5678_9ABC_DEF0,
                     {5'b00010, 5'b01000, 5'b00001, 5'b10000},
                     {4'd0, 4'd0, 4'd0, 4'd0}, {4'd1, 4'd1, 4'd4, 4'd4}, 0, 1'b1, 0, 0),
               64'h1234_5678_9ABC_DEF0, 5'b11011, 6};
    // reset asserted mid-BUSY
    tab[5] = '{mk_op(1'b1, 4'hF, 4'hC, 1'b1, 64'h5555_6666_7777_8888,
                     {5'b11111, 5'b11111, 5'b11111, 5'b11111},
                     {4'd0, 4'd0, 4'd0, 4'd0}, {4'd6, 4'd6, 4'd1, 4'd1}, 0, 1'b1, 2, 4),
               64'h0, 5'b0, 0};
    // scalar after reset, lane 0 masked out of status, late accept
    tab[6] = '{mk_op(1'b0, 4'b1110, 4'hA, 1'b0, 64'h0101_0202_0303_BEEF,
                     {5'b11111, 5'b11111, 5'b11111, 5'b00100},
                     {4'd0, 4'd0, 4'd0, 4'd3}, {4'd1, 4'd1, 4'd1, 4'd2}, 0, 1'b1, 0, 0),
               64'h0000_0000_0000_BEEF, 5'b00000, 6};

    for (int i = 0; i < 7; i++)
      run_op(tab[i].op, tab[i].exp_res, tab[i].exp_stat, tab[i].exp_done);

    // randomized ops against the reference model
    for (int n = 0; n < 30; n++) begin
      ro.vec = 1'($urandom); ro.mask = 4'($urandom); ro.tag = 4'($urandom);
      ro.ext = 1'($urandom); ro.vals = {$urandom, $urandom}; ro.stats = 20'($urandom);
      for (int k = 0; k < NL; k++) begin
        ro.acc[k] = 4'($urandom_range(0, 4));
        ro.lat[k] = 4'($urandom_range(1, 5));
      end
      ro.hold = $urandom_range(0, 3);
      ro.retire = (n == 29) ? 1'b1 : 1'($urandom);
      ro.abort_kind = 0; ro.abort_at = 0;
      run_op(ro, model_res(ro), model_stat(ro), model_done(ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
